dcache_miss_unit: RTL and testbench

//  D$-side initiator for the cache-miss memory interface. Takes one line miss from the data cache, optionally writes back the dirty victim, then fetches the new line.

---
 rtl/dcache_miss_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_dcache_miss_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_unit.sv
// Data-cache miss unit.
// Accepts one line miss from the D$. If the victim is dirty, it first writes the
// victim back. It then fetches the new line. The fill (or an error) is returned
// as a one-cycle pulse. Every output is driven straight from a flop.
module dcache_miss_unit #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_ID   = 1,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  // miss request from the D$
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  evict_dirty,
  input  logic [ADDR_WIDTH-1:0] evict_addr,
  input  logic [LINE_WIDTH-1:0] evict_data,
  // request towards the memory arbiter
  output logic                  req_valid_miss,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_is_store,
  output logic [LINE_WIDTH-1:0] req_data,
  // shared response bus
  input  logic                  rsp_valid_miss,
  input  logic                  rsp_cache_id,
  input  logic                  rsp_bus_error,
  input  logic [LINE_WIDTH-1:0] rsp_data_miss,
  // completion towards the D$
  output logic                  fill_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [LINE_WIDTH-1:0] fill_data,
  output logic                  fill_error
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WB_REQ    = 3'd1;
  localparam logic [2:0] ST_WB_WAIT   = 3'd2;
  localparam logic [2:0] ST_FILL_REQ  = 3'd3;
  localparam logic [2:0] ST_FILL_WAIT = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;

  // The timer only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1'b1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [LINE_WIDTH-1:0] ZERO_LINE = {LINE_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic                  OWN_ID    = CACHE_ID[0];

  logic [2:0]            state_r;
  logic [2:0]            next_state_s;
  logic [ADDR_WIDTH-1:0] miss_addr_r;
  logic [TW-1:0]         timer_r;

  logic                  rsp_match_s;
  logic                  timeout_s;
  logic                  in_wait_s;

  logic                  fill_error_s;
  logic [LINE_WIDTH-1:0] fill_data_s;

  logic [ADDR_WIDTH-1:0] req_addr_s;
  logic                  req_is_store_s;
  logic [LINE_WIDTH-1:0] req_data_s;

  logic                  miss_ready_r;
  logic                  req_valid_r;
  logic [ADDR_WIDTH-1:0] req_addr_r;
  logic                  req_is_store_r;
  logic [LINE_WIDTH-1:0] req_data_r;
  logic                  fill_valid_r;
  logic [ADDR_WIDTH-1:0] fill_addr_r;
  logic [LINE_WIDTH-1:0] fill_data_r;
  logic                  fill_error_r;

  // Qualify the response bus, the wait states and the timer expiry.
  always_comb begin
    rsp_match_s = rsp_valid_miss && (rsp_cache_id == OWN_ID);
    in_wait_s   = (state_r == ST_WB_WAIT) || (state_r == ST_FILL_WAIT);
    timeout_s   = in_wait_s && (timer_r == TIMER_LAST);
  end

  // Next-state logic plus the completion status to latch when moving to RESP.
  always_comb begin
    next_state_s = state_r;
    fill_error_s = 1'b0;
    fill_data_s  = ZERO_LINE;
    case (state_r)
      ST_IDLE: begin
        if (miss_valid) begin
          if (evict_dirty) begin
            next_state_s = ST_WB_REQ;
          end else begin
            next_state_s = ST_FILL_REQ;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WB_REQ: begin
        next_state_s = ST_WB_WAIT;
      end
      ST_WB_WAIT: begin
        // A match takes priority over a timeout in the same cycle.
        if (rsp_match_s) begin
          if (rsp_bus_error) begin
            next_state_s = ST_RESP;
            fill_error_s = 1'b1;
          end else begin
            next_state_s = ST_FILL_REQ;
          end
        end else if (timeout_s) begin
          next_state_s = ST_RESP;
          fill_error_s = 1'b1;
        end else begin
          next_state_s = ST_WB_WAIT;
        end
      end
      ST_FILL_REQ: begin
        next_state_s = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (rsp_match_s) begin
          next_state_s = ST_RESP;
          fill_error_s = rsp_bus_error;
          if (rsp_bus_error) begin
            fill_data_s = ZERO_LINE;
          end else begin
            fill_data_s = rsp_data_miss;
          end
        end else if (timeout_s) begin
          next_state_s = ST_RESP;
          fill_error_s = 1'b1;
        end else begin
          next_state_s = ST_FILL_WAIT;
        end
      end
      ST_RESP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Build the request fields for the upcoming REQ cycle; otherwise hold them.
  always_comb begin
    req_addr_s     = req_addr_r;
    req_is_store_s = req_is_store_r;
    req_data_s     = req_data_r;
    if (next_state_s == ST_WB_REQ) begin
      req_addr_s     = evict_addr;
      req_is_store_s = 1'b1;
      req_data_s     = evict_data;
    end else if (next_state_s == ST_FILL_REQ) begin
      // A clean miss goes straight from IDLE, before miss_addr_r is loaded.
      if (state_r == ST_IDLE) begin
        req_addr_s = miss_addr;
      end else begin
        req_addr_s = miss_addr_r;
      end
      req_is_store_s = 1'b0;
      req_data_s     = ZERO_LINE;
    end else begin
      req_addr_s     = req_addr_r;
      req_is_store_s = req_is_store_r;
      req_data_s     = req_data_r;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture the line address of an accepted miss for the fill and the report.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_addr_r <= ZERO_ADDR;
    end else if ((state_r == ST_IDLE) && miss_valid) begin
      miss_addr_r <= miss_addr;
    end else begin
      miss_addr_r <= miss_addr_r;
    end
  end

  // Response timer. It is cleared in each REQ cycle, which is always the cycle
  // just before a WAIT state. It counts non-matching WAIT cycles and saturates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_r <= TIMER_ZERO;
    end else if ((state_r == ST_WB_REQ) || (state_r == ST_FILL_REQ)) begin
      timer_r <= TIMER_ZERO;
    end else if (in_wait_s && !rsp_match_s && (timer_r != TIMER_MAX)) begin
      timer_r <= timer_r + TIMER_ONE;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Registered request outputs. The valid signal pulses for one cycle, and the
  // fields hold until the next request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_valid_r    <= 1'b0;
      req_addr_r     <= ZERO_ADDR;
      req_is_store_r <= 1'b0;
      req_data_r     <= ZERO_LINE;
    end else begin
      req_valid_r    <= (next_state_s == ST_WB_REQ) || (next_state_s == ST_FILL_REQ);
      req_addr_r     <= req_addr_s;
      req_is_store_r <= req_is_store_s;
      req_data_r     <= req_data_s;
    end
  end

  // Registered handshake and completion outputs. The status is latched on the
  // transition into RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_ready_r <= 1'b1;
      fill_valid_r <= 1'b0;
      fill_addr_r  <= ZERO_ADDR;
      fill_data_r  <= ZERO_LINE;
      fill_error_r <= 1'b0;
    end else begin
      miss_ready_r <= (next_state_s == ST_IDLE);
      fill_valid_r <= (next_state_s == ST_RESP);
      if (next_state_s == ST_RESP) begin
        fill_addr_r  <= miss_addr_r;
        fill_data_r  <= fill_data_s;
        fill_error_r <= fill_error_s;
      end else begin
        fill_addr_r  <= fill_addr_r;
        fill_data_r  <= fill_data_r;
        fill_error_r <= fill_error_r;
      end
    end
  end

  assign miss_ready     = miss_ready_r;
  assign req_valid_miss = req_valid_r;
  assign req_addr       = req_addr_r;
  assign req_is_store   = req_is_store_r;
  assign req_data       = req_data_r;
  assign fill_valid     = fill_valid_r;
  assign fill_addr      = fill_addr_r;
  assign fill_data      = fill_data_r;
  assign fill_error     = fill_error_r;

endmodule

// File: tb/tb_dcache_miss_unit.sv
// Directed self-checking bench for dcache_miss_unit.
// Inputs are driven and outputs are sampled on the falling clock edge.
// "cycle k" is the clock period after the k-th rising edge following acceptance.
// The main instance uses a long timeout. A second instance with TIMEOUT=8 is used
// for the timeout scenario.
module tb_dcache_miss_unit;

  localparam int LW = 128;
  localparam int AW = 32;

  logic          clock;
  logic          reset;
  logic          miss_valid;
  logic          miss_valid8;
  logic [AW-1:0] miss_addr;
  logic          evict_dirty;
  logic [AW-1:0] evict_addr;
  logic [LW-1:0] evict_data;
  logic          rsp_valid_miss;
  logic          rsp_cache_id;
  logic          rsp_bus_error;
  logic [LW-1:0] rsp_data_miss;

  logic          miss_ready, req_valid_miss, req_is_store, fill_valid, fill_error;
  logic [AW-1:0] req_addr, fill_addr;
  logic [LW-1:0] req_data, fill_data;

  logic          miss_ready8, req_valid8, req_is_store8, fill_valid8, fill_error8;
  logic [AW-1:0] req_addr8, fill_addr8;
  logic [LW-1:0] req_data8, fill_data8;

  int total;
  int bad;

  dcache_miss_unit #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CACHE_ID(1), .TIMEOUT(32)) u_dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .evict_dirty(evict_dirty), .evict_addr(evict_addr), .evict_data(evict_data),
    .req_valid_miss(req_valid_miss), .req_addr(req_addr), .req_is_store(req_is_store),
    .req_data(req_data),
    .rsp_valid_miss(rsp_valid_miss), .rsp_cache_id(rsp_cache_id),
    .rsp_bus_error(rsp_bus_error), .rsp_data_miss(rsp_data_miss),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_error(fill_error)
  );

  dcache_miss_unit #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CACHE_ID(1), .TIMEOUT(8)) u_dut8 (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid8), .miss_ready(miss_ready8), .miss_addr(miss_addr),
    .evict_dirty(evict_dirty), .evict_addr(evict_addr), .evict_data(evict_data),
    .req_valid_miss(req_valid8), .req_addr(req_addr8), .req_is_store(req_is_store8),
    .req_data(req_data8),
    .rsp_valid_miss(rsp_valid_miss), .rsp_cache_id(rsp_cache_id),
    .rsp_bus_error(rsp_bus_error), .rsp_data_miss(rsp_data_miss),
    .fill_valid(fill_valid8), .fill_addr(fill_addr8), .fill_data(fill_data8),
    .fill_error(fill_error8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic rsp_off();
    rsp_valid_miss = 1'b0;
    rsp_cache_id   = 1'b0;
    rsp_bus_error  = 1'b0;
    rsp_data_miss  = {LW{1'b0}};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    miss_valid = 1'b0; miss_valid8 = 1'b0; miss_addr = 32'h0;
    evict_dirty = 1'b0; evict_addr = 32'h0; evict_data = {LW{1'b0}};
    rsp_off();
    tick(); tick();
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", miss_ready); end
    total++; if (req_valid_miss !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", req_valid_miss); end
    total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL reset_fill got=%b want=0", fill_valid); end
    total++; if ({req_addr, req_is_store, fill_addr, fill_error} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin
      bad++; $display("FAIL reset_fields got=%h/%b/%h/%b want=0", req_addr, req_is_store, fill_addr, fill_error); end
    total++; if ((req_data | fill_data) !== {LW{1'b0}}) begin bad++; $display("FAIL reset_data got=%h/%h want=0", req_data, fill_data); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_clean_miss();
    logic [LW-1:0] d;
    int stray;
    d = 128'hDEADBEEF_00000000_00000000_00000001;
    miss_valid = 1'b1; miss_addr = 32'h100; evict_dirty = 1'b0;
    tick();  // cycle 1
    miss_valid = 1'b0; miss_addr = 32'hFFFF_FFF0;
    total++; if ({req_valid_miss, req_is_store, req_addr} !== {1'b1, 1'b0, 32'h100}) begin
      bad++; $display("FAIL clean_req got=%b/%b/%h want=1/0/00000100", req_valid_miss, req_is_store, req_addr); end
    total++; if ((req_data !== {LW{1'b0}}) || (miss_ready !== 1'b0)) begin
      bad++; $display("FAIL clean_req_data got=%h ready=%b want=0 ready=0", req_data, miss_ready); end
    stray = 0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (req_valid_miss !== 1'b0 || fill_valid !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL clean_quiet got=%0d want=0", stray); end
    rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_data_miss = d;  // cycle 10
    tick();  // cycle 11
    rsp_off();
    total++; if ({fill_valid, fill_error, fill_addr} !== {1'b1, 1'b0, 32'h100}) begin
      bad++; $display("FAIL clean_fill got=%b/%b/%h want=1/0/00000100", fill_valid, fill_error, fill_addr); end
    total++; if (fill_data !== d) begin bad++; $display("FAIL clean_fill_data got=%h want=%h", fill_data, d); end
    tick();  // cycle 12
    total++; if ({fill_valid, miss_ready} !== 2'b01) begin bad++; $display("FAIL clean_after got=%b%b want=01", fill_valid, miss_ready); end
  endtask

  task automatic test_dirty_miss();
    logic [LW-1:0] d;
    logic [LW-1:0] a5;
    d  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    a5 = {16{8'hA5}};
    miss_valid = 1'b1; miss_addr = 32'h200; evict_dirty = 1'b1;
    evict_addr = 32'h80; evict_data = a5;
    tick();  // cycle 1: writeback request
    miss_valid = 1'b0; miss_addr = 32'h0; evict_dirty = 1'b0;
    evict_addr = 32'h0; evict_data = {LW{1'b0}};
    total++; if ({req_valid_miss, req_is_store, req_addr} !== {1'b1, 1'b1, 32'h80}) begin
      bad++; $display("FAIL dirty_wb_req got=%b/%b/%h want=1/1/00000080", req_valid_miss, req_is_store, req_addr); end
    total++; if (req_data !== a5) begin bad++; $display("FAIL dirty_wb_data got=%h want=%h", req_data, a5); end
    tick(); tick();  // cycle 3
    total++; if ({req_valid_miss, req_is_store, req_addr} !== {1'b0, 1'b1, 32'h80}) begin
      bad++; $display("FAIL dirty_wb_hold got=%b/%b/%h want=0/1/00000080", req_valid_miss, req_is_store, req_addr); end
    rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_data_miss = {LW{1'b1}};
    tick();  // cycle 4: load request
    rsp_off();
    total++; if ({req_valid_miss, req_is_store, req_addr} !== {1'b1, 1'b0, 32'h200}) begin
      bad++; $display("FAIL dirty_ld_req got=%b/%b/%h want=1/0/00000200", req_valid_miss, req_is_store, req_addr); end
    total++; if ((req_data !== {LW{1'b0}}) || (fill_valid !== 1'b0)) begin
      bad++; $display("FAIL dirty_ld_data got=%h fill=%b want=0 fill=0", req_data, fill_valid); end
    tick();  // cycle 5
    total++; if (req_valid_miss !== 1'b0) begin bad++; $display("FAIL dirty_ld_pulse got=%b want=0", req_valid_miss); end
    rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_data_miss = d;
    tick();  // cycle 6
    rsp_off();
    total++; if ({fill_valid, fill_error, fill_addr} !== {1'b1, 1'b0, 32'h200}) begin
      bad++; $display("FAIL dirty_fill got=%b/%b/%h want=1/0/00000200", fill_valid, fill_error, fill_addr); end
    total++; if (fill_data !== d) begin bad++; $display("FAIL dirty_fill_data got=%h want=%h", fill_data, d); end
    tick();
  endtask

  task automatic test_wb_error();
    int stray;
    miss_valid = 1'b1; miss_addr = 32'h300; evict_dirty = 1'b1;
    evict_addr = 32'h40; evict_data = {16{8'h3C}};
    tick();  // cycle 1
    miss_valid = 1'b0; evict_dirty = 1'b0;
    tick();  // cycle 2
    rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_bus_error = 1'b1; rsp_data_miss = {LW{1'b1}};
    tick();  // cycle 3
    rsp_off();
    total++; if ({fill_valid, fill_error, fill_addr} !== {1'b1, 1'b1, 32'h300}) begin
      bad++; $display("FAIL wberr_fill got=%b/%b/%h want=1/1/00000300", fill_valid, fill_error, fill_addr); end
    total++; if ((fill_data !== {LW{1'b0}}) || (req_valid_miss !== 1'b0)) begin
      bad++; $display("FAIL wberr_data got=%h req=%b want=0 req=0", fill_data, req_valid_miss); end
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (req_valid_miss !== 1'b0 || fill_valid !== 1'b0 || miss_ready !== 1'b1) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL wberr_no_load got=%0d want=0", stray); end
  endtask

  task automatic test_timeout();
    logic [LW-1:0] d;
    int stray;
    d = 128'hCAFEF00D_11112222_33334444_55556666;
    // Run A: no response at all.
    miss_valid8 = 1'b1; miss_addr = 32'h400; evict_dirty = 1'b0;
    tick();  // cycle 1
    miss_valid8 = 1'b0;
    total++; if ({req_valid8, req_is_store8, req_addr8} !== {1'b1, 1'b0, 32'h400}) begin
      bad++; $display("FAIL to_req got=%b/%b/%h want=1/0/00000400", req_valid8, req_is_store8, req_addr8); end
    stray = 0;
    for (int k = 2; k <= 9; k++) begin
      tick();
      if (fill_valid8 !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL to_early got=%0d want=0", stray); end
    tick();  // cycle 10: 8 cycles after entering FILL_WAIT at cycle 2
    total++; if ({fill_valid8, fill_error8, fill_addr8} !== {1'b1, 1'b1, 32'h400}) begin
      bad++; $display("FAIL to_fill got=%b/%b/%h want=1/1/00000400", fill_valid8, fill_error8, fill_addr8); end
    total++; if (fill_data8 !== {LW{1'b0}}) begin bad++; $display("FAIL to_data got=%h want=0", fill_data8); end
    tick();
    // Run B: a match lands in the timeout cycle and wins.
    miss_valid8 = 1'b1; miss_addr = 32'h480;
    tick();  // cycle 1
    miss_valid8 = 1'b0;
    for (int k = 2; k <= 9; k++) tick();
    rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_data_miss = d;  // cycle 9
    tick();  // cycle 10
    rsp_off();
    total++; if ({fill_valid8, fill_error8, fill_addr8} !== {1'b1, 1'b0, 32'h480}) begin
      bad++; $display("FAIL to_race got=%b/%b/%h want=1/0/00000480", fill_valid8, fill_error8, fill_addr8); end
    total++; if (fill_data8 !== d) begin bad++; $display("FAIL to_race_data got=%h want=%h", fill_data8, d); end
    tick();
  endtask

  task automatic test_foreign_id();
    logic [LW-1:0] d;
    d = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    miss_valid = 1'b1; miss_addr = 32'h500; evict_dirty = 1'b0;
    tick();  // cycle 1
    miss_valid = 1'b0;
    tick();  // cycle 2
    rsp_valid_miss = 1'b1; rsp_cache_id = 1'b0; rsp_data_miss = {LW{1'b1}};
    tick();  // cycle 3
    rsp_off();
    total++; if ({fill_valid, miss_ready} !== 2'b00) begin bad++; $display("FAIL foreign_ignored got=%b%b want=00", fill_valid, miss_ready); end
    tick();  // cycle 4
    rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_data_miss = d;
    tick();  // cycle 5
    rsp_off();
    total++; if ({fill_valid, fill_error, fill_addr} !== {1'b1, 1'b0, 32'h500}) begin
      bad++; $display("FAIL foreign_fill got=%b/%b/%h want=1/0/00000500", fill_valid, fill_error, fill_addr); end
    total++; if (fill_data !== d) begin bad++; $display("FAIL foreign_data got=%h want=%h", fill_data, d); end
    total++; if (fill_valid8 !== 1'b0) begin bad++; $display("FAIL idle_ignore got=%b want=0", fill_valid8); end
    tick();
  endtask

  task automatic test_reset_mid();
    int stray;
    miss_valid = 1'b1; miss_addr = 32'h600; evict_dirty = 1'b1;
    evict_addr = 32'h700; evict_data = {16{8'h5A}};
    tick();  // cycle 1
    miss_valid = 1'b0; evict_dirty = 1'b0;
    tick();  // cycle 2: WB_WAIT
    reset = 1'b0;
    #1;
    total++; if ({miss_ready, req_valid_miss, fill_valid} !== 3'b100) begin
      bad++; $display("FAIL rstmid_async got=%b%b%b want=100", miss_ready, req_valid_miss, fill_valid); end
    tick();
    reset = 1'b1;
    rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_data_miss = {LW{1'b1}};
    tick();
    rsp_off();
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      if (fill_valid !== 1'b0 || req_valid_miss !== 1'b0 || miss_ready !== 1'b1) stray++;
      tick();
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL rstmid_stale got=%0d want=0", stray); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wb_error();
    test_timeout();
    test_foreign_id();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
